// File: rtl/alu_issue_responder.sv
// Purpose: FU-side endpoint of the ALU issue handshake for four SIMD slots, with round-robin completion retirement.
// Latency: a slot selected at T is busy from T+1 and can present its completion record at T+LATENCY+1 at the earliest.
// Backpressure: done_valid/done_wfid/done_unit hold stable until done_ack; an unacked slot stays in DONE_WAIT and is not issuable.
module alu_issue_responder #(
    parameter int WFID_W  = 6,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        c_alu_select,
    input  logic [WFID_W-1:0] c_issued_wfid,
    output logic [3:0]        f_alu_ready,
    output logic              done_valid,
    output logic [WFID_W-1:0] done_wfid,
    output logic [1:0]        done_unit,
    input  logic              done_ack,
    output logic              protocol_err
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BUSY      = 2'd1,
        DONE_WAIT = 2'd2
    } slot_state_t;

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    slot_state_t       state  [4];
    logic [3:0]        count  [4];
    logic [WFID_W-1:0] wfid   [4];
    logic [3:0]        loaded;
    logic [1:0]        rr_ptr;

    logic [3:0] idle_vec;
    logic [3:0] cand_vec;
    logic       sel_multi;
    logic       busy_hit;
    logic [3:0] accept;
    logic       retire;
    logic       load;
    logic       pick_vld;
    logic [1:0] pick_idx;
    logic [1:0] scan_idx;

    // Decode per-slot idle/candidate vectors from registered state.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            idle_vec[i] = (state[i] == IDLE);
            cand_vec[i] = (state[i] == DONE_WAIT) && !loaded[i];
        end
    end

    assign f_alu_ready = idle_vec;

    // A select is legal only if one-hot and aimed at an idle slot.
    assign sel_multi = |(c_alu_select & (c_alu_select - 4'd1));
    assign busy_hit  = |(c_alu_select & ~idle_vec);
    assign accept    = sel_multi ? 4'b0000 : (c_alu_select & idle_vec);

    assign retire = done_valid && done_ack;

    // Round-robin scan starting at rr_ptr+1; descending loop so the nearest slot wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = rr_ptr;
        scan_idx = rr_ptr;
        for (int k = 4; k >= 1; k--) begin
            scan_idx = rr_ptr + 2'(k);
            if (cand_vec[scan_idx]) begin
                pick_vld = 1'b1;
                pick_idx = scan_idx;
            end
        end
    end

    // The output register accepts a new record when empty or draining this cycle.
    assign load = (!done_valid || done_ack) && pick_vld;

    // Per-slot occupancy FSMs: issue, countdown, wait for retirement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                state[i] <= IDLE;
                count[i] <= 4'd0;
                wfid[i]  <= '0;
            end
            loaded <= 4'b0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                case (state[i])
                    IDLE: begin
                        if (accept[i]) begin
                            wfid[i] <= c_issued_wfid;
                            if (LATENCY == 1) begin
                                state[i] <= DONE_WAIT;
                                count[i] <= 4'd0;
                            end else begin
                                state[i] <= BUSY;
                                count[i] <= LAT_M1;
                            end
                        end
                    end
                    BUSY: begin
                        // Leaving on the decrement to zero puts the slot in DONE_WAIT exactly LATENCY cycles after issue.
                        if (count[i] <= 4'd1) begin
                            state[i] <= DONE_WAIT;
                            count[i] <= 4'd0;
                        end else begin
                            count[i] <= count[i] - 4'd1;
                        end
                    end
                    DONE_WAIT: begin
                        if (retire && (done_unit == 2'(i))) begin
                            state[i]  <= IDLE;
                            loaded[i] <= 1'b0;
                        end else if (load && (pick_idx == 2'(i))) begin
                            loaded[i] <= 1'b1;
                        end
                    end
                    default: begin
                        state[i] <= IDLE;
                    end
                endcase
            end
        end
    end

    // Completion record register and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_valid <= 1'b0;
            done_wfid  <= '0;
            done_unit  <= 2'd0;
            rr_ptr     <= 2'd3;
        end else if (load) begin
            done_valid <= 1'b1;
            done_wfid  <= wfid[pick_idx];
            done_unit  <= pick_idx;
            rr_ptr     <= pick_idx;
        end else if (retire) begin
            done_valid <= 1'b0;
        end
    end

    // Sticky protocol error; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            protocol_err <= 1'b0;
        end else if (sel_multi || busy_hit) begin
            protocol_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_issue_responder.sv
// Purpose: self-checking bench for alu_issue_responder (LATENCY=4 main instance, LATENCY=1 side instance).
// Latency: inputs change 2ns after the rising edge; outputs are read 2ns after the edge and at the falling edge.
// Backpressure: done_ack is driven per scenario; a negedge monitor checks hold-stability and scoreboard order.
module tb_alu_issue_responder;
    localparam int W = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [3:0]   sel, sel1;
    logic [W-1:0] wfid, wfid1;
    logic         ack, ack1;
    logic [3:0]   rdy, rdy1;
    logic         dv, dv1;
    logic [W-1:0] dw, dw1;
    logic [1:0]   du, du1;
    logic         perr, perr1;

    alu_issue_responder #(.WFID_W(W), .LATENCY(4)) u_dut (
        .clk(clk), .rst(rst), .c_alu_select(sel), .c_issued_wfid(wfid),
        .f_alu_ready(rdy), .done_valid(dv), .done_wfid(dw), .done_unit(du),
        .done_ack(ack), .protocol_err(perr)
    );

    alu_issue_responder #(.WFID_W(W), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst(rst), .c_alu_select(sel1), .c_issued_wfid(wfid1),
        .f_alu_ready(rdy1), .done_valid(dv1), .done_wfid(dw1), .done_unit(du1),
        .done_ack(ack1), .protocol_err(perr1)
    );

    int vectors     = 0;
    int miscompares = 0;
    logic [7:0] sb_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Retirement monitor: compares each accepted record with the scoreboard and checks hold stability.
    logic       prev_hold = 1'b0;
    logic [7:0] prev_rec  = 8'h00;
    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold)
                chk("hold", {23'd0, dv, du, dw}, {23'd0, 1'b1, prev_rec});
            if (dv && ack) begin
                if (sb_q.size() == 0)
                    chk("spurious_done", {23'd0, 1'b1, du, dw}, 32'd0);
                else
                    chk("retire", {24'd0, du, dw}, {24'd0, sb_q.pop_front()});
            end
            prev_hold = dv && !ack;
            prev_rec  = {du, dw};
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        sel = 4'd0;  wfid = '0;  ack = 1'b0;
        sel1 = 4'd0; wfid1 = '0; ack1 = 1'b0;
        sb_q.delete();
        tick();
        tick();
        chk("rst_ready", rdy, 4'hf);
        chk("rst_valid", dv, 0);
        chk("rst_wfid", dw, 0);
        chk("rst_unit", du, 0);
        chk("rst_perr", perr, 0);
        chk("rst_ready_l1", rdy1, 4'hf);
        rst = 1'b0;
        tick();
    endtask

    task automatic drain(input int budget);
        for (int n = 0; n < budget && sb_q.size() != 0; n++)
            tick();
        chk("drain", sb_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        do_reset();

        // Single issue with ack tied high.
        ack = 1'b1;
        sel = 4'b0001; wfid = 6'h2A;
        sb_q.push_back({2'd0, 6'h2A});
        tick();
        sel = 4'd0;
        chk("single_ready_busy", rdy, 4'b1110);
        tick(); tick(); tick();
        chk("single_not_early", dv, 0);
        tick();
        chk("single_valid", dv, 1);
        chk("single_unit", du, 0);
        chk("single_wfid", dw, 6'h2A);
        tick();
        chk("single_ready_back", rdy, 4'hf);
        chk("single_valid_off", dv, 0);
        chk("single_sb", sb_q.size(), 0);

        // Fill all four slots with ack held low, then drain one per cycle.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            sel = 4'(1 << i); wfid = 6'(i + 1);
            sb_q.push_back({2'(i), 6'(i + 1)});
            tick();
        end
        sel = 4'd0;
        chk("fill_ready_zero", rdy, 4'h0);
        tick();
        chk("fill_valid", dv, 1);
        chk("fill_unit0", du, 0);
        repeat (5) tick();
        chk("fill_still_unit0", du, 0);
        tick();
        ack = 1'b1;
        chk("fill_b2b_0", {du, dw}, {2'd0, 6'd1});
        tick();
        chk("fill_b2b_1", {du, dw}, {2'd1, 6'd2});
        tick();
        chk("fill_b2b_2", {du, dw}, {2'd2, 6'd3});
        tick();
        chk("fill_b2b_3", {du, dw}, {2'd3, 6'd4});
        tick();
        chk("fill_empty", dv, 0);
        ack = 1'b0;
        chk("fill_sb", sb_q.size(), 0);

        // Round-robin: slot 1 first sets the pointer, then slot 2 beats slot 0.
        do_reset();
        sel = 4'b0010; wfid = 6'h11; tick();
        sel = 4'b0001; wfid = 6'h10; tick();
        sel = 4'b0100; wfid = 6'h12; tick();
        sel = 4'd0;
        sb_q.push_back({2'd1, 6'h11});
        sb_q.push_back({2'd2, 6'h12});
        sb_q.push_back({2'd0, 6'h10});
        repeat (4) tick();
        chk("rr_first_unit", du, 1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("rr_second_unit", du, 2);
        chk("rr_slot1_ready", rdy[1], 1);
        sel = 4'b0010; wfid = 6'h21;
        sb_q.push_back({2'd1, 6'h21});
        tick();
        sel = 4'd0;
        repeat (4) tick();
        ack = 1'b1;
        drain(12);
        tick();
        chk("rr_done", dv, 0);
        ack = 1'b0;

        // Protocol error: multi-bit select.
        do_reset();
        sel = 4'b0011; wfid = 6'h01;
        tick();
        sel = 4'd0;
        chk("perr_multi", perr, 1);
        chk("perr_multi_ready", rdy, 4'hf);
        repeat (6) tick();
        chk("perr_multi_no_done", dv, 0);
        chk("perr_sticky", perr, 1);
        do_reset();

        // Protocol error: select a busy slot; original wfid must survive.
        ack = 1'b1;
        sel = 4'b0001; wfid = 6'h05;
        sb_q.push_back({2'd0, 6'h05});
        tick();
        sel = 4'b0001; wfid = 6'h3F;
        tick();
        sel = 4'd0;
        chk("perr_busy", perr, 1);
        drain(10);
        tick();
        chk("perr_busy_ready", rdy, 4'hf);
        chk("perr_busy_sticky", perr, 1);
        do_reset();

        // Reset mid-operation with two slots busy and a record pending.
        sel = 4'b0001; wfid = 6'h07; tick();
        sel = 4'd0; tick(); tick();
        sel = 4'b0010; wfid = 6'h08; tick();
        sel = 4'b0100; wfid = 6'h09; tick();
        sel = 4'd0;
        chk("midrst_pre_valid", dv, 1);
        chk("midrst_pre_ready", rdy, 4'b1000);
        rst = 1'b1;
        sb_q.delete();
        #1;
        chk("midrst_ready", rdy, 4'hf);
        chk("midrst_valid", dv, 0);
        tick(); tick();
        rst = 1'b0;
        ack = 1'b1;
        for (int n = 0; n < 8; n++) begin
            tick();
            chk("midrst_no_done", dv, 0);
        end
        ack = 1'b0;

        // LATENCY=1 instance: select slot 3, present next-next cycle, ready after ack.
        sel1 = 4'b1000; wfid1 = 6'h3F;
        tick();
        sel1 = 4'd0;
        chk("l1_ready_busy", rdy1, 4'b0111);
        chk("l1_not_early", dv1, 0);
        tick();
        chk("l1_valid", dv1, 1);
        chk("l1_unit", du1, 3);
        chk("l1_wfid", dw1, 6'h3F);
        ack1 = 1'b1;
        tick();
        ack1 = 1'b0;
        chk("l1_ready_back", rdy1, 4'hf);
        chk("l1_valid_off", dv1, 0);

        chk("final_sb", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
